// File: rtl/mmio_port_unit.sv
// Memory-mapped port block: PortOut register, synchronized PortIn, W1C status and a TX FIFO.
// Reads are combinational with zero latency; define MMIO_IRQ_EN to add the IRQ_EN register and the irq output.
module mmio_port_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          IN_WIDTH   = 8,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic [31:0]         tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
`ifdef MMIO_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [2:0]          offset;
  logic                wr_en;
  logic [IN_WIDTH-1:0] sync1, sync2, prev;
  logic                in_changed, overflow;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                full, empty, pop, push, ovf_set;
  logic                unused_addr;

  assign unused_addr = ^Address[1:0];
  assign offset      = Address[4:2];
  assign Hit         = (Address[31:5] == BASE_ADDR[31:5]);
  assign wr_en       = MemWrite & Hit;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = !empty;
  assign pop      = tx_valid & tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = wr_en && (offset == 3'd3) && (!full || pop);
  assign ovf_set  = wr_en && (offset == 3'd3) && full && !pop;
  assign tx_data  = tx_valid ? mem[rd_ptr] : 32'd0;

`ifdef MMIO_IRQ_EN
  logic [1:0] irq_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && offset == 3'd4) irq_en <= WriteData[1:0];
      irq <= (irq_en[0] & in_changed) | (irq_en[1] & overflow);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut    <= '0;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      in_changed <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
      if (wr_en && offset == 3'd0) PortOut <= WriteData;
      // Flag sets take priority over a same-cycle W1C clear.
      if (sync2 != prev)
        in_changed <= 1'b1;
      else if (wr_en && offset == 3'd2 && WriteData[0])
        in_changed <= 1'b0;
      if (ovf_set)
        overflow <= 1'b1;
      else if (wr_en && offset == 3'd2 && WriteData[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= WriteData;
  end

  always_comb begin
    ReadData = 32'd0;
    if (Hit && MemRead) begin
      case (offset)
        3'd0: ReadData = PortOut;
        3'd1: ReadData = 32'(sync2);
        3'd2: ReadData = {23'd0, 5'(count), overflow, empty, full, in_changed};
`ifdef MMIO_IRQ_EN
        3'd4: ReadData = {30'd0, irq_en};
`endif
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule
